// File: rtl/icache_direct_pkg.sv
// Shared geometry and FSM encodings for the direct-mapped instruction cache.
package icache_direct_pkg;

    localparam int WORD_SIZE   = 16;
    localparam int OFFSET_BITS = 2;
    localparam int INDEX_BITS  = 3;
    localparam int TAG_BITS    = WORD_SIZE - OFFSET_BITS - INDEX_BITS;
    localparam int LINE_WORDS  = 1 << OFFSET_BITS;
    localparam int NUM_LINES   = 1 << INDEX_BITS;
    localparam int LINE_BITS   = WORD_SIZE * LINE_WORDS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MISS = 2'd1,
        FILL = 2'd2
    } cacheState_e;

    typedef logic [LINE_WORDS-1:0][WORD_SIZE-1:0] line_t;

endpackage

// File: rtl/icache_sat_counter.sv
// Saturating event counter; sticks at all-ones instead of wrapping.
module icache_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: 0-cycle hits, whole-line refill
// on a miss, flush-all, and saturating hit/miss counters.
module icache_direct
    import icache_direct_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cpu_read,
    input  logic [WORD_SIZE-1:0] cpu_addr,
    output logic [WORD_SIZE-1:0] cpu_data,
    output logic                 cpu_ready,
    input  logic                 flush,
    output logic                 mem_read,
    output logic [WORD_SIZE-1:0] mem_addr,
    input  logic [LINE_BITS-1:0] mem_data,
    input  logic                 mem_ready,
    output logic [WORD_SIZE-1:0] hit_count,
    output logic [WORD_SIZE-1:0] miss_count
);

    logic [TAG_BITS-1:0]    reqTag;
    logic [INDEX_BITS-1:0]  reqIndex;
    logic [OFFSET_BITS-1:0] reqOffset;
    logic [TAG_BITS-1:0]    fillTag;
    logic [INDEX_BITS-1:0]  fillIndex;

    logic [NUM_LINES-1:0]   valid;
    logic [TAG_BITS-1:0]    tagMem  [NUM_LINES];
    line_t                  dataMem [NUM_LINES];

    cacheState_e state, nextState;
    logic        flushPend;
    logic        hit, missStart, flushNow, fillWrite;

    assign reqTag    = cpu_addr[WORD_SIZE-1 -: TAG_BITS];
    assign reqIndex  = cpu_addr[OFFSET_BITS +: INDEX_BITS];
    assign reqOffset = cpu_addr[OFFSET_BITS-1:0];

    // The latched line base doubles as the refill target.
    assign fillTag   = mem_addr[WORD_SIZE-1 -: TAG_BITS];
    assign fillIndex = mem_addr[OFFSET_BITS +: INDEX_BITS];

    always_comb begin
        nextState = state;
        hit       = 1'b0;
        missStart = 1'b0;
        flushNow  = 1'b0;
        fillWrite = 1'b0;
        case (state)
            IDLE: begin
                flushNow  = flush | flushPend;
                hit       = cpu_read & valid[reqIndex] &
                            (tagMem[reqIndex] == reqTag) & ~flushNow;
                missStart = cpu_read & ~hit & ~flushNow;
                if (missStart)
                    nextState = MISS;
            end
            MISS: begin
                if (mem_ready) begin
                    fillWrite = 1'b1;
                    nextState = FILL;
                end
            end
            FILL:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Gate data with hit so the port reads zero while storage is uninitialised.
    assign cpu_ready = hit;
    assign cpu_data  = hit ? dataMem[reqIndex][reqOffset] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            flushPend <= 1'b0;
            mem_read  <= 1'b0;
            mem_addr  <= '0;
            valid     <= '0;
        end else begin
            state <= nextState;

            if (flushNow)
                flushPend <= 1'b0;
            else if (flush)
                flushPend <= 1'b1;

            if (missStart) begin
                mem_read <= 1'b1;
                mem_addr <= {reqTag, reqIndex, {OFFSET_BITS{1'b0}}};
            end else if (fillWrite) begin
                mem_read <= 1'b0;
            end

            // A flush pending across a refill wins once back in IDLE.
            if (flushNow)
                valid <= '0;
            else if (fillWrite)
                valid[fillIndex] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fillWrite) begin
            dataMem[fillIndex] <= mem_data;
            tagMem[fillIndex]  <= fillTag;
        end
    end

    icache_sat_counter #(.W(WORD_SIZE)) hitCounter (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (hit),
        .count   (hit_count)
    );

    icache_sat_counter #(.W(WORD_SIZE)) missCounter (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (missStart),
        .count   (miss_count)
    );

endmodule

// File: tb/tb_icache_direct.sv
// Scoreboard bench for icache_direct: directed fetches push expected words and
// line addresses; a CPU monitor and a memory model pop and compare.
module tb_icache_direct;
    import icache_direct_pkg::*;

    localparam int LAT     = 3;
    localparam int SAT_N   = 65540;
    localparam int MAX_CYC = 60;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 cpu_read = 1'b0;
    logic [WORD_SIZE-1:0] cpu_addr = '0;
    logic [WORD_SIZE-1:0] cpu_data;
    logic                 cpu_ready;
    logic                 flush = 1'b0;
    logic                 mem_read;
    logic [WORD_SIZE-1:0] mem_addr;
    logic [LINE_BITS-1:0] mem_data = '0;
    logic                 mem_ready = 1'b0;
    logic [WORD_SIZE-1:0] hit_count;
    logic [WORD_SIZE-1:0] miss_count;

    int checks = 0;
    int fails  = 0;
    logic [WORD_SIZE-1:0] expData[$];
    logic [WORD_SIZE-1:0] expMemAddr[$];

    icache_direct dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_read   (cpu_read),
        .cpu_addr   (cpu_addr),
        .cpu_data   (cpu_data),
        .cpu_ready  (cpu_ready),
        .flush      (flush),
        .mem_read   (mem_read),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Backing store: word at address a holds a - 16'h16 (so 0x20..0x23 = A..D).
    function automatic logic [LINE_BITS-1:0] memLine(input logic [WORD_SIZE-1:0] base);
        logic [LINE_BITS-1:0] l;
        for (int i = 0; i < LINE_WORDS; i++)
            l[WORD_SIZE*i +: WORD_SIZE] = base + WORD_SIZE'(i) - 16'h0016;
        return l;
    endfunction

    // CPU-side monitor
    always @(negedge clk) begin
        if (reset_n && cpu_ready) begin
            if (expData.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpectedReady: got data %0h at addr %0h expected no response", cpu_data, cpu_addr);
            end else begin
                check("cpu_data", {16'h0, cpu_data}, {16'h0, expData.pop_front()});
            end
        end
    end

    // Memory model: answers each new line request after LAT cycles
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && mem_read) begin
                if (expMemAddr.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpectedMemRead: got addr %0h expected no request", mem_addr);
                end else begin
                    check("mem_addr", {16'h0, mem_addr}, {16'h0, expMemAddr.pop_front()});
                end
                repeat (LAT - 1) @(posedge clk);
                #1;
                mem_data  = memLine(mem_addr);
                mem_ready = 1'b1;
                @(posedge clk);
                #1;
                mem_ready = 1'b0;
            end
        end
    end

    task automatic doReset();
        reset_n  = 1'b0;
        cpu_read = 1'b0;
        flush    = 1'b0;
        repeat (6) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Present a fetch and wait for cpu_ready; lat<0 skips the latency check.
    task automatic fetch(input logic [WORD_SIZE-1:0] a, input logic [WORD_SIZE-1:0] d,
                         input int lat, input int swAt, input logic [WORD_SIZE-1:0] sw,
                         input int flAt);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        expData.push_back(d);
        cpu_read = 1'b1;
        cpu_addr = a;
        while (n <= MAX_CYC) begin
            @(negedge clk);
            if (cpu_ready) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            n++;
            flush = (n == flAt);
            if (n == swAt)
                cpu_addr = sw;
        end
        if (!got) begin
            checks++;
            fails++;
            $display("FAIL fetchTimeout: addr %0h got no ready after %0d cycles expected ready", a, n);
        end else if (lat >= 0) begin
            check("latency", n, lat);
        end
        @(posedge clk);
        #1 flush = 1'b0;
    endtask

    initial begin
        // Reset state with a request already asserted
        cpu_read = 1'b1;
        cpu_addr = 16'h0000;
        repeat (2) @(negedge clk);
        check("rstReady",  {31'h0, cpu_ready}, 32'h0);
        check("rstMemRd",  {31'h0, mem_read},  32'h0);
        check("rstData",   {16'h0, cpu_data},  32'h0);
        check("rstHits",   {16'h0, hit_count}, 32'h0);
        check("rstMisses", {16'h0, miss_count}, 32'h0);

        // Release: address 0 misses; then reset mid-miss drops mem_read at once
        expMemAddr.push_back(16'h0000);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("missMemRd",   {31'h0, mem_read},   32'h1);
        check("missMemAddr", {16'h0, mem_addr},   32'h0);
        check("missCount0",  {16'h0, miss_count}, 32'h1);
        #2 reset_n = 1'b0;
        cpu_read = 1'b0;
        #1;
        check("asyncMemRd",  {31'h0, mem_read},   32'h0);
        check("asyncMisses", {16'h0, miss_count}, 32'h0);
        doReset();

        // Cold miss, then hits across the line
        expMemAddr.push_back(16'h0020);
        fetch(16'h0021, 16'h000B, 5, -1, 16'h0, -1);
        for (int i = 0; i < 4; i++)
            fetch(16'h0020 + 16'(i), 16'h000A + 16'(i), 0, -1, 16'h0, -1);
        cpu_read = 1'b0;
        check("coldHits",   {16'h0, hit_count},  32'd5);
        check("coldMisses", {16'h0, miss_count}, 32'd1);
        doReset();

        // Conflict eviction on index 0
        expMemAddr.push_back(16'h0020);
        expMemAddr.push_back(16'h0420);
        expMemAddr.push_back(16'h0020);
        fetch(16'h0020, 16'h000A, 5, -1, 16'h0, -1);
        fetch(16'h0420, 16'h040A, 5, -1, 16'h0, -1);
        fetch(16'h0020, 16'h000A, 5, -1, 16'h0, -1);
        cpu_read = 1'b0;
        check("conflictMisses", {16'h0, miss_count}, 32'd3);
        check("conflictHits",   {16'h0, hit_count},  32'd3);
        doReset();

        // Address changes mid-miss: 0x40 fill completes, then 0x80 misses
        expMemAddr.push_back(16'h0040);
        expMemAddr.push_back(16'h0080);
        fetch(16'h0040, 16'h006A, 10, 1, 16'h0080, -1);
        fetch(16'h0081, 16'h006B, 0, -1, 16'h0, -1);
        cpu_read = 1'b0;
        check("switchMisses", {16'h0, miss_count}, 32'd2);
        doReset();

        // Flush during MISS: line filled then invalidated, request re-misses
        expMemAddr.push_back(16'h0060);
        expMemAddr.push_back(16'h0060);
        fetch(16'h0060, 16'h004A, 11, -1, 16'h0, 2);
        check("flushMisses", {16'h0, miss_count}, 32'd2);
        check("flushHits",   {16'h0, hit_count},  32'd1);
        // Flush in IDLE suppresses a would-be hit for that cycle
        expMemAddr.push_back(16'h0060);
        flush = 1'b1;
        fetch(16'h0061, 16'h004B, 6, -1, 16'h0, -1);
        cpu_read = 1'b0;
        check("idleFlushMisses", {16'h0, miss_count}, 32'd3);
        doReset();

        // Hit counter saturation
        expMemAddr.push_back(16'h0020);
        fetch(16'h0020, 16'h000A, 5, -1, 16'h0, -1);
        for (int i = 0; i < SAT_N; i++)
            expData.push_back(16'h000A);
        repeat (SAT_N) @(posedge clk);
        #1 cpu_read = 1'b0;
        @(negedge clk);
        check("satHits",   {16'h0, hit_count},  32'h0000FFFF);
        check("satMisses", {16'h0, miss_count}, 32'd1);

        repeat (4) @(negedge clk);
        check("dataQueueEmpty", expData.size(),    0);
        check("addrQueueEmpty", expMemAddr.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1500000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $fatal(1, "watchdog");
    end

endmodule
